load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's execute stage and Data_Memory; it feeds Data_Memory's MemRW/addr/dataW and consumes dataR.
//  Data_Memory is word-only with no byte enables. This block therefore provides:
//   - RV32I LB/LH/LW/LBU/LHU: lane extraction plus sign or zero extension.
//   - SB/SH: read-modify-write merge. SW: direct word write.
//  The core stalls on req_ready=0 and takes the result on resp_valid.
// PARAMETERS
//  XLEN       32  data/address width (only 32 supported)
//  ADDR_LSB    2  byte-offset bits stripped to form the word address
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-low (0 = reset)
//  req_valid    in   1   core presents a memory op
//  req_ready    out  1   block can accept (1 only in IDLE)
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32I load/store funct3
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (low byte/half used for SB/SH)
//  resp_valid   out  1   one-cycle pulse: op complete
//  resp_rdata   out  32  extended load data; 0 for stores
//  resp_err     out  1   misaligned-access flag (see CONFIGURATION)
//  mem_MemRW    out  1   to Data_Memory MemRW (1 = write)
//  mem_addr     out  32  to Data_Memory addr; always word-aligned
//  mem_dataW    out  32  to Data_Memory dataW
//  mem_dataR    in   32  from Data_Memory dataR (combinational read, write at clk edge)
// BEHAVIOUR
//  Reset (rst=0 sampled):
//   - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0.
//   - mem_MemRW=0, mem_addr=0, mem_dataW=0.
//   - mem_MemRW is gated by rst, so reset asserted in a write cycle suppresses that write.
//  FSM states: IDLE, ACCESS, WRITE, RESP.
//   - IDLE: req_ready=1. On req_valid, register we/funct3/addr/wdata, then go to ACCESS.
//   - ACCESS: mem_addr={addr[31:2],2'b00}.
//     - Load: register extracted and extended mem_dataR into resp_rdata, then RESP.
//     - SW: mem_MemRW=1, mem_dataW=wdata, then RESP.
//     - SB/SH: register mem_dataR as old word, then WRITE.
//   - WRITE: mem_MemRW=1, mem_dataW=old word with the addressed byte/half lane replaced, then RESP.
//   - RESP: resp_valid=1 for exactly one cycle, then IDLE. A new request is accepted only in the following IDLE cycle.
//  Latency (accept edge -> resp_valid high): load and SW = 2 cycles; SB/SH = 3 cycles.
//  mem_MemRW is 1 only in SW-ACCESS and WRITE.
//  Lanes:
//   - Byte: selected by addr[1:0].
//   - Half: selected by addr[1]. addr[0] is ignored for halfwords unless the trap is enabled.
//  Extension:
//   - LB/LH: sign-extend from bit 7/15.
//   - LBU/LHU: zero-extend.
//  Unsupported funct3:
//   - Loads 011/110/111 are treated as LW.
//   - Stores with funct3[1:0]=11 or funct3[2]=1 are treated by funct3[1:0] (11 -> SW).
//  resp_rdata holds its value until the next load completes; it is 0 after a store.
//  req inputs are ignored outside IDLE.
// CONFIGURATION
//  Macro LSU_MISALIGN_TRAP_EN. Misaligned means: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//  Defined:
//   - A misaligned request goes IDLE->RESP directly with resp_err=1 and resp_rdata=0.
//   - No memory read or write occurs; latency is 1 cycle.
//  Undefined:
//   - resp_err is tied to 0 and low address bits are ignored as described above.
// STRUCTURE
//  lsu_pkg holds:
//   - funct3 localparams (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
//   - typedef enum logic [1:0] lsu_state_t {IDLE, ACCESS, WRITE, RESP}.
//  One combinational sub-module, lsu_lane_align:
//   - load path: extract+extend(word, addr[1:0], funct3).
//   - store path: merge(old_word, wdata, addr[1:0], funct3).
//   - The top level keeps the FSM and registers.
// TESTING (bench holds Data_Memory model; check MemRW pulses and latencies)
//  1. SW 0xcacacaca @0x14, then LW @0x14: resp_rdata=0xcacacaca, one MemRW pulse, both latency 2.
//  2. SB wdata 0x000000AB @0x15 over word 0xcacacaca: mem word=0xcacaabca.
//     Then LB @0x15 -> 0xffffffab; LBU @0x15 -> 0x000000ab; SB latency 3.
//  3. SH 0x00008001 @0x16 over 0xcacaabca: word=0x8001abca.
//     Then LH @0x16 -> 0xffff8001; LHU @0x16 -> 0x00008001.
//  4. LW @0x1F with LSU_MISALIGN_TRAP_EN: resp_err=1, resp_rdata=0, latency 1, MemRW never 1.
//     Without the macro: returns the word at 0x1C, resp_err=0.
//  5. SB in flight, rst=0 during its WRITE cycle: no MemRW pulse, mem word unchanged.
//     Outputs are 0 and req_ready=1 the cycle after rst returns to 1.
//  6. req_valid held high for LW,LW back-to-back: second op accepted only in the IDLE cycle after RESP.
//     resp_valid never high for 2 consecutive cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN (see load_store_unit.sv).
package lsu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ADDR_LSB = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

  // Request fields kept for the duration of one memory operation.
  typedef struct packed {
    logic                we;
    logic [2:0]          funct3;
    logic [ADDR_LSB-1:0] off;
  } lsu_req_t;

  // Access size comes from funct3[1:0] for loads and stores alike: 00 byte, 01 half, else word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [ADDR_LSB-1:0] off);
    logic w_mis;
    case (funct3[1:0])
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = off[0];
      default: w_mis = (off != 2'b00);
    endcase
    return w_mis;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and Data_Memory-side signals of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_MemRW;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_dataW;
  logic [XLEN-1:0] mem_dataR;

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_MemRW, mem_addr, mem_dataW
  );

  // Core plus Data_Memory as seen from outside the unit.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataR,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_MemRW, mem_addr, mem_dataW
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling for a word-only memory: load extract+extend and store merge.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0]     i_word,
  input  logic [XLEN-1:0]     i_wdata,
  input  logic [ADDR_LSB-1:0] i_off,
  input  logic [2:0]          i_funct3,
  output logic [XLEN-1:0]     o_load_c,
  output logic [XLEN-1:0]     o_merge_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes of the memory word.
  always_comb begin
    w_byte = i_word[{i_off, 3'b000} +: 8];
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  // Load result: sign/zero extension; unlisted funct3 codes read the whole word.
  always_comb begin
    o_load_c = i_word;
    case (i_funct3)
      F3_B:    o_load_c = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_c = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_c = {24'h0, w_byte};
      F3_HU:   o_load_c = {16'h0, w_half};
      default: o_load_c = i_word;
    endcase
  end

  // Store word: replace only the addressed lane of the old word; word stores pass through.
  always_comb begin
    o_merge_c = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_merge_c = i_word;
        o_merge_c[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      2'b01:   o_merge_c = i_off[1] ? {i_wdata[15:0], i_word[15:0]} : {i_word[31:16], i_wdata[15:0]};
      default: o_merge_c = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-only Data_Memory (no byte enables).
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
// Build option: define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses with
// resp_err and skip the memory access; otherwise low address bits are ignored.
module load_store_unit
  import lsu_pkg::*;
(
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);

  lsu_state_t      r_state, w_state_nxt;
  lsu_req_t        r_req, w_req_nxt;
  logic            r_req_ready, w_req_ready_nxt;
  logic            r_resp_valid, w_resp_valid_nxt;
  logic [XLEN-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic            r_resp_err, w_resp_err_nxt;
  logic            r_mem_memrw, w_mem_memrw_nxt;
  logic [XLEN-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [XLEN-1:0] r_mem_dataw, w_mem_dataw_nxt;
  logic            w_trap;
  logic [XLEN-1:0] w_load_c;
  logic [XLEN-1:0] w_merge_c;

  // r_mem_dataw holds the store data until the merge replaces it with the full word.
  lsu_lane_align u_lane_align (
    .i_word    (bus.mem_dataR),
    .i_wdata   (r_mem_dataw),
    .i_off     (r_req.off),
    .i_funct3  (r_req.funct3),
    .o_load_c  (w_load_c),
    .o_merge_c (w_merge_c)
  );

  // Misaligned-request detection; constant 0 when the trap is not built in.
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = is_misaligned(bus.req_funct3, bus.req_addr[ADDR_LSB-1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_mem_memrw_nxt  = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_dataw_nxt  = r_mem_dataw;

    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_req_nxt.we     = bus.req_we;
          w_req_nxt.funct3 = bus.req_funct3;
          w_req_nxt.off    = bus.req_addr[ADDR_LSB-1:0];
          w_mem_dataw_nxt  = bus.req_wdata;
          w_resp_err_nxt   = w_trap;
          if (w_trap) begin
            w_state_nxt      = RESP;
            w_resp_rdata_nxt = '0;
          end else begin
            w_state_nxt     = ACCESS;
            w_mem_addr_nxt  = {bus.req_addr[XLEN-1:ADDR_LSB], ADDR_LSB'(0)};
            // Word stores (funct3[1]=1) write directly during ACCESS.
            w_mem_memrw_nxt = bus.req_we & bus.req_funct3[1];
          end
        end
      end
      ACCESS: begin
        if (!r_req.we) begin
          w_resp_rdata_nxt = w_load_c;
          w_state_nxt      = RESP;
        end else if (r_req.funct3[1]) begin
          w_resp_rdata_nxt = '0;
          w_state_nxt      = RESP;
        end else begin
          w_mem_dataw_nxt = w_merge_c;
          w_mem_memrw_nxt = 1'b1;
          w_state_nxt     = WRITE;
        end
      end
      WRITE: begin
        w_resp_rdata_nxt = '0;
        w_state_nxt      = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_req_ready_nxt  = (w_state_nxt == IDLE);
    w_resp_valid_nxt = (w_state_nxt == RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_memrw  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_dataw  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_mem_memrw  <= w_mem_memrw_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_dataw  <= w_mem_dataw_nxt;
    end
  end

  // MemRW is gated by reset so that asserting reset in a write cycle cancels the write.
  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_MemRW  = r_mem_memrw & rst;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_dataW  = r_mem_dataw;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    int          acc;
    bit          st;
    int          widx;
    logic [31:0] word;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data_Memory model: combinational read, write on the clock edge.
  logic [31:0] dmem [0:63];
  always @(posedge clk) if (bus.mem_MemRW) dmem[bus.mem_addr[7:2]] <= bus.mem_dataW;
  assign bus.mem_dataR = dmem[bus.mem_addr[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  ref_bytes [0:255];
  exp_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  bit          prev_valid = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  // Reference: operate on individual bytes, little-endian.
  task automatic model(input bit we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, output exp_t e);
    int size;
    int base;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = '0;
    e.err = 1'b0; e.rdata = '0; e.nwr = 0; e.st = we; e.widx = int'(a) / 4; e.lat = 2; e.acc = 0;
    if (TRAP && (int'(a) % size) != 0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else begin
      base = int'(a) - (int'(a) % size);
      if (we) begin
        for (int i = 0; i < size; i++) ref_bytes[base+i] = wd[8*i +: 8];
        e.nwr = 1;
        e.lat = (size == 4) ? 2 : 3;
      end else begin
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[base+i];
        if (!f3[2] && size == 1 && v[7])  v = v | 32'hffffff00;
        if (!f3[2] && size == 2 && v[15]) v = v | 32'hffff0000;
        e.rdata = v;
      end
    end
    e.word = ref_word(e.widx);
  endtask

  // Monitor: count memory writes and check each response against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.mem_MemRW) begin
        wr_cnt++;
        chk("mem_addr_aligned", {30'h0, bus.mem_addr[1:0]}, 32'h0);
      end
      if (bus.resp_valid) begin
        chk("resp_single_cycle", {31'h0, prev_valid}, 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 want no response pending");
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_err", {31'h0, bus.resp_err}, {31'h0, e.err});
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("memrw_pulses", 32'(wr_cnt), 32'(e.nwr));
          if (e.st) chk("mem_word", dmem[e.widx], e.word);
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
        end
        wr_cnt = 0;
      end
      prev_valid = bus.resp_valid;
    end
  end

  // Present one request (called just after a clock edge); returns the accept cycle.
  task automatic issue(input bit we, input logic [2:0] f3, input logic [7:0] a,
                       input logic [31:0] wd, input bit keep, output int acc);
    exp_t e;
    int n;
    n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = {24'h0, a}; bus.req_wdata = wd;
    while (!bus.req_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    acc = cyc;
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready got 0 want 1");
      bus.req_valid = 1'b0;
    end else begin
      model(we, f3, a, wd, e);
      e.acc = cyc;
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (!keep) bus.req_valid = 1'b0;
      // Busy-period noise on the request fields must be ignored.
      bus.req_we = 1'($urandom); bus.req_funct3 = 3'($urandom);
      bus.req_addr = $urandom; bus.req_wdata = $urandom;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || !bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: outstanding got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int a1;
    int a2;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'($urandom);
    for (int w = 0; w < 64; w++) dmem[w] = ref_word(w);
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_memrw", {31'h0, bus.mem_MemRW}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_dataw", bus.mem_dataW, 32'h0);
    @(posedge clk); #1;

    // SW then LW at 0x14
    issue(1'b1, F3_W, 8'h14, 32'hcacacaca, 1'b0, a1);
    issue(1'b0, F3_W, 8'h14, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t1_lw", last_rdata, 32'hcacacaca);
    chk("t1_word", dmem[5], 32'hcacacaca);

    // SB 0xAB at 0x15, then LB/LBU
    issue(1'b1, F3_B, 8'h15, 32'h000000ab, 1'b0, a1);
    wait_idle();
    chk("t2_word", dmem[5], 32'hcacaabca);
    issue(1'b0, F3_B, 8'h15, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t2_lb", last_rdata, 32'hffffffab);
    issue(1'b0, F3_BU, 8'h15, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t2_lbu", last_rdata, 32'h000000ab);

    // SH 0x8001 at 0x16, then LH/LHU
    issue(1'b1, F3_H, 8'h16, 32'h00008001, 1'b0, a1);
    wait_idle();
    chk("t3_word", dmem[5], 32'h8001abca);
    issue(1'b0, F3_H, 8'h16, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t3_lh", last_rdata, 32'hffff8001);
    issue(1'b0, F3_HU, 8'h16, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t3_lhu", last_rdata, 32'h00008001);

    // Misaligned LW at 0x1F
    issue(1'b0, F3_W, 8'h1f, 32'h0, 1'b0, a1);
    wait_idle();
    chk("t4_err", {31'h0, last_err}, {31'h0, TRAP});
    chk("t4_rdata", last_rdata, TRAP ? 32'h0 : ref_word(7));

    // Back-to-back LW with req_valid held high
    issue(1'b0, F3_W, 8'h20, 32'h0, 1'b1, a1);
    issue(1'b0, F3_W, 8'h24, 32'h0, 1'b0, a2);
    wait_idle();
    chk("t6_accept_gap", 32'(a2 - a1), 32'd3);

    // Reset during the WRITE cycle of an SB
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h31; bus.req_wdata = 32'h0000005a;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_write_cycle", {31'h0, bus.mem_MemRW}, 32'h1);
    rst = 1'b0;
    #1;
    chk("t5_memrw_gated", {31'h0, bus.mem_MemRW}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("t5_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("t5_resp_rdata", bus.resp_rdata, 32'h0);
    chk("t5_memrw", {31'h0, bus.mem_MemRW}, 32'h0);
    chk("t5_mem_addr", bus.mem_addr, 32'h0);
    chk("t5_mem_dataw", bus.mem_dataW, 32'h0);
    chk("t5_word_kept", dmem[12], ref_word(12));
    chk("t5_no_write", 32'(wr_cnt), 32'h0);
    @(posedge clk); #1;

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      issue(1'($urandom), 3'($urandom), 8'($urandom), $urandom, 1'($urandom_range(0, 1)), a1);
      if ($urandom_range(0, 7) == 0) wait_idle();
    end
    wait_idle();
    for (int w = 0; w < 64; w++) chk("final_mem", dmem[w], ref_word(w));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
